// File: rtl/rv32i_pkg.sv
// Shared definitions for the rv32i front end.
// Fetch state encoding, NOP word and PC step.
package rv32i_pkg;

    localparam logic [31:0] NOP              = 32'h0000_0013;
    localparam logic [31:0] PC_STEP          = 32'd4;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    localparam logic [2:0] FS_REQ   = 3'd0;
    localparam logic [2:0] FS_WAIT  = 3'd1;
    localparam logic [2:0] FS_HOLD  = 3'd2;
    localparam logic [2:0] FS_DRAIN = 3'd3;
    localparam logic [2:0] FS_HALT  = 3'd4;

    typedef enum logic [2:0] {
        F_REQ   = FS_REQ,
        F_WAIT  = FS_WAIT,
        F_HOLD  = FS_HOLD,
        F_DRAIN = FS_DRAIN,
        F_HALT  = FS_HALT
    } fetch_state_e;

endpackage

// File: rtl/fetch_pc.sv
// Program counter for the fetch stage.
// Holds, steps by one word, or loads a redirect target.
module fetch_pc
    import rv32i_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        load_i,
    input  logic        incr_i,
    input  logic [31:0] target_i,
    output logic [31:0] pc_o,
    output logic        target_aligned_o
);

    logic [31:0] pc_q;
    logic [31:0] pc_d;

    assign target_aligned_o = (target_i[1:0] == 2'b00);
    assign pc_o             = pc_q;

    // load and incr are never raised together by the fetch FSM
    always_comb begin
        pc_d = pc_q;
        unique case (1'b1)
            load_i:  pc_d = target_i;
            incr_i:  pc_d = pc_q + PC_STEP;
            default: pc_d = pc_q;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: one outstanding imem read, registered word to decode.
// Redirects flush in-flight fetches; misaligned targets halt fetch.
module instruction_fetch
    import rv32i_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clock,
    input  logic        reset_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instruction,
    output logic [31:0] instr_pc,
    output logic        fetch_misaligned
);

    fetch_state_e state_q;
    fetch_state_e state_d;
    logic         armed_q;
    logic [31:0]  instr_q;
    logic [31:0]  instr_d;
    logic [31:0]  ipc_q;
    logic [31:0]  ipc_d;
    logic         mis_q;
    logic         mis_d;

    logic [31:0]  pc;
    logic         pc_load;
    logic         pc_incr;
    logic         tgt_aligned;
    logic         redir_ok;
    logic         redir_bad;
    logic         req_fire;

    fetch_pc #(
        .RESET_PC(RESET_PC)
    ) u_pc (
        .clock           (clock),
        .reset_n         (reset_n),
        .load_i          (pc_load),
        .incr_i          (pc_incr),
        .target_i        (redirect_pc),
        .pc_o            (pc),
        .target_aligned_o(tgt_aligned)
    );

    assign redir_ok  = redirect_valid && tgt_aligned;
    assign redir_bad = redirect_valid && !tgt_aligned;

    // armed_q keeps the request low during the first cycle after reset release
    assign imem_req_valid   = (state_q == F_REQ) && armed_q;
    assign imem_addr        = pc;
    assign req_fire         = imem_req_valid && imem_req_ready;
    assign instr_valid      = (state_q == F_HOLD);
    assign instruction      = instr_q;
    assign instr_pc         = ipc_q;
    assign fetch_misaligned = mis_q;

    always_comb begin
        state_d = state_q;
        instr_d = instr_q;
        ipc_d   = ipc_q;
        mis_d   = mis_q;
        pc_load = 1'b0;
        pc_incr = 1'b0;
        unique case (state_q)
            F_REQ: begin
                if (redir_ok) begin
                    pc_load = 1'b1;
                    state_d = req_fire ? F_DRAIN : F_REQ;
                end else if (redir_bad) begin
                    mis_d   = 1'b1;
                    state_d = req_fire ? F_DRAIN : F_HALT;
                end else if (req_fire) begin
                    state_d = F_WAIT;
                end
            end
            F_WAIT: begin
                if (redir_ok) begin
                    pc_load = 1'b1;
                    state_d = imem_rsp_valid ? F_REQ : F_DRAIN;
                end else if (redir_bad) begin
                    mis_d   = 1'b1;
                    state_d = imem_rsp_valid ? F_HALT : F_DRAIN;
                end else if (imem_rsp_valid) begin
                    instr_d = imem_rsp_data;
                    ipc_d   = pc;
                    pc_incr = 1'b1;
                    state_d = F_HOLD;
                end
            end
            F_HOLD: begin
                if (redir_ok) begin
                    pc_load = 1'b1;
                    state_d = F_REQ;
                end else if (redir_bad) begin
                    mis_d   = 1'b1;
                    state_d = F_HALT;
                end else if (instr_ready) begin
                    state_d = F_REQ;
                end
            end
            F_DRAIN: begin
                if (redir_ok) begin
                    pc_load = 1'b1;
                    mis_d   = 1'b0;
                end else if (redir_bad) begin
                    mis_d   = 1'b1;
                end
                if (imem_rsp_valid) begin
                    state_d = mis_d ? F_HALT : F_REQ;
                end
            end
            F_HALT: begin
                if (redir_ok) begin
                    pc_load = 1'b1;
                    mis_d   = 1'b0;
                    state_d = F_REQ;
                end else if (redir_bad) begin
                    mis_d   = 1'b1;
                end
            end
            default: state_d = F_REQ;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= F_REQ;
            armed_q <= 1'b0;
            instr_q <= NOP;
            ipc_q   <= 32'h0000_0000;
            mis_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            armed_q <= 1'b1;
            instr_q <= instr_d;
            ipc_q   <= ipc_d;
            mis_q   <= mis_d;
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch.
// Inputs change on negedge; a latency-programmable imem model answers requests.
module tb_instruction_fetch;

    logic        clock;
    logic        reset_n;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instruction;
    logic [31:0] instr_pc;
    logic        fetch_misaligned;

    int          n_cmp;
    int          n_err;
    int          lat;
    int          cnt;
    logic [31:0] rsp_addr;
    logic [31:0] held_instr;
    int          req_seen;

    instruction_fetch #(
        .RESET_PC(32'h0000_0000)
    ) dut (
        .clock           (clock),
        .reset_n         (reset_n),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_addr       (imem_addr),
        .imem_rsp_valid  (imem_rsp_valid),
        .imem_rsp_data   (imem_rsp_data),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .instr_valid     (instr_valid),
        .instr_ready     (instr_ready),
        .instruction     (instruction),
        .instr_pc        (instr_pc),
        .fetch_misaligned(fetch_misaligned)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [31:0] memf(input logic [31:0] a);
        if (a == 32'h0) return 32'h0050_0093;
        return a | 32'h0000_0013;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic nedge();
        @(negedge clock);
    endtask

    task automatic wait_valid(input int max);
        int n;
        n = 0;
        while (!instr_valid && n < max) begin
            nedge();
            n++;
        end
        chk("wait_valid", {31'b0, instr_valid}, 32'd1);
    endtask

    // memory model: acts 1 time unit after each negedge
    initial begin
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        cnt            = 0;
        rsp_addr       = 32'h0;
        forever begin
            @(negedge clock);
            #1;
            imem_rsp_valid = 1'b0;
            if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin
                    imem_rsp_valid = 1'b1;
                    imem_rsp_data  = memf(rsp_addr);
                end
            end
            if (imem_req_valid && imem_req_ready) begin
                cnt      = lat;
                rsp_addr = imem_addr;
            end
        end
    end

    initial begin
        n_cmp          = 0;
        n_err          = 0;
        lat            = 1;
        imem_req_ready = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        instr_ready    = 1'b0;
        reset_n        = 1'b1;
        #1 reset_n     = 1'b0;
        nedge();
        nedge();
        chk("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_instr_valid", {31'b0, instr_valid}, 32'd0);
        chk("rst_instruction", instruction, 32'h0000_0013);
        chk("rst_instr_pc", instr_pc, 32'h0);
        chk("rst_misaligned", {31'b0, fetch_misaligned}, 32'd0);

        // 1: first fetch with zero-wait memory
        reset_n = 1'b1;
        nedge();
        chk("c1_req_valid", {31'b0, imem_req_valid}, 32'd1);
        chk("c1_addr", imem_addr, 32'h0);
        nedge();
        chk("c2_instr_valid", {31'b0, instr_valid}, 32'd0);
        nedge();
        chk("c3_instr_valid", {31'b0, instr_valid}, 32'd1);
        chk("c3_instruction", instruction, 32'h0050_0093);
        chk("c3_instr_pc", instr_pc, 32'h0);

        // 2: decode stalls for 5 cycles
        for (int i = 0; i < 5; i++) begin
            nedge();
            chk("stall_instr", instruction, 32'h0050_0093);
            chk("stall_valid", {31'b0, instr_valid}, 32'd1);
            chk("stall_noreq", {31'b0, imem_req_valid}, 32'd0);
        end
        instr_ready = 1'b1;
        lat         = 3;
        nedge();
        instr_ready = 1'b0;
        chk("next_valid_low", {31'b0, instr_valid}, 32'd0);
        chk("next_addr", imem_addr, 32'h4);

        // 3: redirect while waiting on a slow response
        nedge();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h100;
        nedge();
        redirect_valid = 1'b0;
        lat            = 1;
        chk("drain_noreq", {31'b0, imem_req_valid}, 32'd0);
        nedge();
        nedge();
        chk("redir_req", {31'b0, imem_req_valid}, 32'd1);
        chk("redir_addr", imem_addr, 32'h100);
        wait_valid(10);
        chk("redir_instr", instruction, 32'h0000_0113);
        chk("redir_pc", instr_pc, 32'h100);

        // 4: misaligned redirect halts, aligned redirect resumes
        redirect_valid = 1'b1;
        redirect_pc    = 32'h102;
        nedge();
        redirect_valid = 1'b0;
        chk("mis_flag", {31'b0, fetch_misaligned}, 32'd1);
        chk("mis_valid", {31'b0, instr_valid}, 32'd0);
        req_seen = 0;
        for (int i = 0; i < 4; i++) begin
            if (imem_req_valid) req_seen++;
            nedge();
        end
        chk("halt_noreq", req_seen, 32'd0);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h200;
        nedge();
        redirect_valid = 1'b0;
        chk("resume_flag", {31'b0, fetch_misaligned}, 32'd0);
        chk("resume_req", {31'b0, imem_req_valid}, 32'd1);
        chk("resume_addr", imem_addr, 32'h200);
        wait_valid(10);
        chk("resume_instr", instruction, 32'h0000_0213);
        chk("resume_pc", instr_pc, 32'h200);

        // 5: PC wrap at top of address space
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        nedge();
        redirect_valid = 1'b0;
        chk("top_addr", imem_addr, 32'hFFFF_FFFC);
        wait_valid(10);
        chk("top_instr", instruction, 32'hFFFF_FFFF);
        chk("top_pc", instr_pc, 32'hFFFF_FFFC);
        instr_ready = 1'b1;
        nedge();
        instr_ready = 1'b0;
        chk("wrap_addr", imem_addr, 32'h0);
        wait_valid(10);
        chk("wrap_instr", instruction, 32'h0050_0093);
        instr_ready = 1'b1;
        lat         = 4;
        nedge();
        instr_ready = 1'b0;
        chk("pre_rst_addr", imem_addr, 32'h4);

        // 6: asynchronous reset during WAIT, stray response afterwards
        nedge();
        #2 reset_n = 1'b0;
        #1;
        chk("arst_req_valid", {31'b0, imem_req_valid}, 32'd0);
        chk("arst_addr", imem_addr, 32'h0);
        chk("arst_instruction", instruction, 32'h0000_0013);
        chk("arst_instr_valid", {31'b0, instr_valid}, 32'd0);
        nedge();
        reset_n        = 1'b1;
        imem_req_ready = 1'b0;
        lat            = 1;
        nedge();
        chk("rel_req_valid", {31'b0, imem_req_valid}, 32'd1);
        chk("rel_addr", imem_addr, 32'h0);
        nedge();
        nedge();
        chk("stray_valid", {31'b0, instr_valid}, 32'd0);
        chk("stray_req", {31'b0, imem_req_valid}, 32'd1);
        chk("stray_addr", imem_addr, 32'h0);
        imem_req_ready = 1'b1;
        wait_valid(10);
        chk("rel_instr", instruction, 32'h0050_0093);
        chk("rel_pc", instr_pc, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
